spike_event_encoder: RTL and testbench

//   Consumes the TDM neuron core's time-multiplexed membrane output (one Q4.12 sample per cycle, tagged by neuron id).
//   Per-neuron hysteretic threshold detection: emits one spike event {timestep, neuron_id} per upward crossing.

---
 rtl/spike_event_encoder.sv | 111 +++++++++++
 tb/tb_spike_event_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// spike_event_encoder: per-neuron hysteretic threshold detector on a TDM
// membrane stream, feeding spike events {timestep, id} into a small
// first-word-fall-through FIFO with a valid/ready interface.
module spike_event_encoder #(
  parameter  int NEURON_COUNT = 500,
  parameter  int DATA_WIDTH   = 16,
  parameter  int V_TH         = 4096,
  parameter  int V_REARM      = 0,
  parameter  int TS_WIDTH     = 16,
  parameter  int FIFO_DEPTH   = 16,
  localparam int ID_W         = $clog2(NEURON_COUNT),
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         v_valid,
  input  logic signed [DATA_WIDTH-1:0] v_in,
  input  logic        [ID_W-1:0]       neuron_id,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic        [ID_W-1:0]       ev_id,
  output logic        [TS_WIDTH-1:0]   ev_timestep,
  output logic        [CW-1:0]         fifo_count,
  output logic        [TS_WIDTH-1:0]   timestep,
  output logic                         overflow,
  output logic        [15:0]           drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [DATA_WIDTH-1:0] TH = DATA_WIDTH'(V_TH);
  localparam logic signed [DATA_WIDTH-1:0] RA = DATA_WIDTH'(V_REARM);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [ID_W-1:0]     id;
  } event_t;

  // detection
  logic [NEURON_COUNT-1:0] armed;
  logic                    in_range, last_id, hit, rearm;

  assign in_range = v_valid && ({1'b0, neuron_id} < (ID_W+1)'(NEURON_COUNT));
  assign last_id  = in_range && (neuron_id == ID_W'(NEURON_COUNT-1));
  assign hit      = in_range &&  armed[neuron_id] && (v_in >= TH);
  assign rearm    = in_range && !armed[neuron_id] && (v_in <  RA);

  // One-deep stage between detection and FIFO; this register is what keeps
  // v_in off any combinational path to the ev_* outputs.
  logic   stg_vld;
  event_t stg_ev;

  // Arm bits, timestep counter and the detection stage register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed    <= '1;
      timestep <= '0;
      stg_vld  <= 1'b0;
      stg_ev   <= '0;
    end else begin
      if (hit)          armed[neuron_id] <= 1'b0;
      else if (rearm)   armed[neuron_id] <= 1'b1;
      if (last_id)      timestep <= timestep + 1'b1;
      stg_vld <= hit;
      if (hit) stg_ev <= '{ts: timestep, id: neuron_id};
    end
  end

  // event FIFO
  event_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, wr_en, drop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = (count != '0) && ev_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_en = stg_vld && (!full || pop);
  assign drop  = stg_vld && full && !pop;

  // Pointers, occupancy and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= stg_ev;
  end

  event_t head;
  assign head        = mem[rd_ptr];
  assign ev_valid    = (count != '0);
  assign ev_id       = ev_valid ? head.id : '0;
  assign ev_timestep = ev_valid ? head.ts : '0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder (TS_WIDTH=4 to exercise wrap).
module tb_spike_event_encoder;

  logic               clk = 1'b0;
  logic               rst;
  logic               v_valid;
  logic signed [15:0] v_in;
  logic        [8:0]  neuron_id;
  logic               ev_valid, ev_ready;
  logic        [8:0]  ev_id;
  logic        [3:0]  ev_timestep;
  logic        [4:0]  fifo_count;
  logic        [3:0]  timestep;
  logic               overflow;
  logic        [15:0] drop_count;

  spike_event_encoder #(.TS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .v_valid(v_valid), .v_in(v_in), .neuron_id(neuron_id),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_timestep(ev_timestep),
    .fifo_count(fifo_count), .timestep(timestep), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [3:0] ts; logic [8:0] id; } ev_t;
  ev_t exp_q[$];

  // reference model state
  bit          marm [500];
  logic [3:0]  mts;
  int          mcnt;
  logic        movf;
  logic [15:0] mdrop;
  logic        sv;
  ev_t         se;
  logic        mpop;
  bit          mon_en = 0;
  int          n0 = 0, n150 = 0, n_pop = 0;

  // Reference model: detection one cycle ahead of the FIFO push.
  always @(posedge clk) begin
    if (!rst) begin
      mcnt = 0; mts = '0; movf = 1'b0; mdrop = '0; sv = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 500; i++) marm[i] = 1'b1;
    end else begin
      mpop = (mcnt != 0) && ev_ready;
      if (sv) begin
        if (mcnt < 16 || mpop) begin exp_q.push_back(se); mcnt++; end
        else begin movf = 1'b1; if (mdrop != 16'hFFFF) mdrop++; end
      end
      if (mpop) mcnt--;
      sv = 1'b0;
      if (v_valid && neuron_id < 500) begin
        if (marm[neuron_id] && v_in >= 4096) begin
          sv = 1'b1; se.ts = mts; se.id = neuron_id; marm[neuron_id] = 1'b0;
        end else if (!marm[neuron_id] && v_in < 0) begin
          marm[neuron_id] = 1'b1;
        end
        if (neuron_id == 499) mts++;
      end
    end
  end

  // Monitor: status every cycle, and events checked as they are accepted.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ev_valid",   ev_valid,   mcnt != 0);
      chk("fifo_count", fifo_count, mcnt);
      chk("timestep",   timestep,   mts);
      chk("overflow",   overflow,   movf);
      chk("drop_count", drop_count, mdrop);
      if (ev_valid && ev_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_id", ev_id, e.id);
          chk("ev_timestep", ev_timestep, e.ts);
          if (ev_id == 9'd0)   n0++;
          if (ev_id == 9'd150) n150++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic smp(input int v, input int id);
    v_valid = 1'b1; v_in = 16'(v); neuron_id = 9'(id);
    @(posedge clk); #1;
    v_valid = 1'b0;
  endtask

  int p0;

  initial begin
    rst = 1'b0; v_valid = 1'b0; v_in = '0; neuron_id = '0; ev_ready = 1'b0;
    idle(3);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_timestep", timestep, 0);
    chk("rst_drop_count", drop_count, 0);
    rst = 1'b1; mon_en = 1;

    // single crossing and latency
    ev_ready = 1'b1;
    smp(4095, 0); smp(0, 499); smp(4096, 0);
    chk("lat_n", ev_valid, 0);
    idle(1);
    chk("lat_n1", ev_valid, 1);
    chk("lat_id", ev_id, 0);
    chk("lat_ts", ev_timestep, 1);
    idle(3);
    chk("id0_events", n0, 1);

    // hysteresis
    smp(5000, 150); smp(3000, 150); smp(5000, 150); smp(-1, 150); smp(4096, 150);
    idle(4);
    chk("id150_events", n150, 2);

    // timestep wrap: one spike every timestep
    for (int t = 0; t < 18; t++) begin
      if (t % 2 == 0) begin smp(4096, 498); smp(-1, 499); end
      else            begin smp(-1, 498);   smp(4096, 499); end
    end
    idle(4);

    // full FIFO with coincident push and pop
    ev_ready = 1'b0;
    for (int i = 0; i < 16; i++) smp(4096, 300 + i);
    idle(2);
    chk("full_count", fifo_count, 16);
    smp(4096, 316);
    ev_ready = 1'b1;
    idle(1);
    ev_ready = 1'b0;
    idle(1);
    chk("pushpop_count", fifo_count, 16);
    chk("pushpop_overflow", overflow, 0);
    ev_ready = 1'b1;
    idle(20);
    chk("drain1_count", fifo_count, 0);

    // overflow
    ev_ready = 1'b0;
    for (int i = 0; i < 20; i++) smp(4096, 200 + i);
    idle(2);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 4);
    ev_ready = 1'b1;
    idle(20);
    chk("drain2_count", fifo_count, 0);

    // reset mid-traffic
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) smp(4096, 320 + i);
    rst = 1'b0;
    idle(3);
    chk("mid_rst_ev_valid", ev_valid, 0);
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_timestep", timestep, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_ev_id", ev_id, 0);
    chk("mid_rst_ev_ts", ev_timestep, 0);
    rst = 1'b1; ev_ready = 1'b1;
    p0 = n_pop;
    smp(4096, 320);
    idle(4);
    chk("post_rst_events", n_pop - p0, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
